lcd_reader: RTL
===============

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter T_AS, default 8, address-setup cycles (EN low, RS/RW valid) before EN rises.
REQ-002 SHALL have parameter T_PW, default 25, EN-high cycles.
REQ-003 SHALL have parameter T_H, default 2, hold cycles after EN falls (RS/RW held).
REQ-004 SHALL have parameter T_REC, default 15, recovery cycles before the next access or done.
REQ-005 SHALL have parameter MAX_POLLS, default 255, busy-flag reads per poll request before timeout.
REQ-006 SHALL have ports: clock  in  1  single system clock, rising edge.
REQ-007 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: req  in  1  start a read access, sampled only in IDLE.
REQ-009 SHALL have ports: rs_sel  in  1  0 = busy-flag/address read, 1 = DDRAM/CGRAM data read.
REQ-010 SHALL have ports: poll  in  1  repeat busy-flag reads until BF clears, valid only with rs_sel=0.
REQ-011 SHALL have ports: ready  out  1  high in IDLE.
REQ-012 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports: rdata  out  8  last captured byte.
REQ-014 SHALL have ports: busy_flag  out  1 and addr_counter  out  7  the fields of the last rs_sel=0 capture.
REQ-015 SHALL have ports: timeout  out  1  poll ended with BF still set.
REQ-016 SHALL have ports: bus_own  out  1  high while this block owns the LCD bus, so the writer path tristates DATA.
REQ-017 SHALL have ports: LCD_DATA_IN  in  8, LCD_EN  out  1, LCD_RS  out  1, LCD_RW  out  1.

Function
REQ-018 SHALL implement states IDLE, SETUP, EN_HIGH, HOLD, RECOVER, with a per-state down-counter sized for the largest parameter.
REQ-019 SHALL, on the rising edge where the state is IDLE and req=1:
- latch rs_sel into LCD_RS;
- latch (poll AND NOT rs_sel) as poll mode;
- clear the poll counter and timeout;
- enter SETUP.
REQ-020 SHALL ignore req outside IDLE, with no queuing.
REQ-021 SHALL drive LCD_RW=1 and bus_own=1 in SETUP, EN_HIGH, HOLD and RECOVER; in IDLE SHALL drive LCD_RW=0 and bus_own=0.
REQ-022 SHALL drive LCD_EN=1 only in EN_HIGH.
REQ-023 SHALL hold LCD_RS stable from SETUP entry through RECOVER exit.
REQ-024 SHALL occupy exactly T_AS, T_PW, T_H and T_REC cycles in SETUP, EN_HIGH, HOLD and RECOVER respectively.
REQ-025 SHALL register LCD_DATA_IN into rdata on the final EN_HIGH cycle.
REQ-026 SHALL, when LCD_RS=0, also load busy_flag=LCD_DATA_IN[7] and addr_counter=LCD_DATA_IN[6:0] on that cycle; otherwise busy_flag and addr_counter are unchanged.
REQ-027 SHALL, at RECOVER exit in poll mode with captured bit7=1 and poll count < MAX_POLLS-1, increment the poll count and re-enter SETUP without asserting done.
REQ-028 SHALL, at RECOVER exit in all other cases, pulse done for one cycle and enter IDLE (ready=1) in that same cycle.
REQ-029 SHALL set timeout=1 with done if poll mode ended with bit7=1.
REQ-030 SHALL have single-access latency: req sampled at edge k → done high during cycle k+1+T_AS+T_PW+T_H+T_REC (k+51 with defaults).
REQ-031 SHALL have poll latency N×(T_AS+T_PW+T_H+T_REC)+1 for N reads, where N ≤ MAX_POLLS.
REQ-032 SHALL accept a new request in the done cycle: req=1 then starts SETUP on the next edge, giving back-to-back accesses.
REQ-033 SHALL hold rdata, busy_flag, addr_counter and timeout until the next capture or the next accepted req (timeout only).
REQ-034 SHALL treat any parameter value of 0 as 1 cycle.

Reset
REQ-035 SHALL, on reset low, immediately and asynchronously force IDLE, LCD_EN=0, LCD_RW=0, LCD_RS=0, bus_own=0, done=0, timeout=0, rdata=0, busy_flag=0, addr_counter=0, and clear counters; ready=1.
REQ-036 SHALL treat reset mid-access (including EN_HIGH) as aborting the access with no done pulse, and EN SHALL fall in the same cycle.
REQ-037 SHALL require one clock edge after reset release before req is sampled.

Verification
REQ-038 Single data read: rs_sel=1, LCD_DATA_IN=8'h41 → EN high exactly 25 cycles, rdata=8'h41, done at k+51, busy_flag/addr_counter unchanged.
REQ-039 Status read: rs_sel=0, poll=0, LCD_DATA_IN=8'h8F → rdata=8'h8F, busy_flag=1, addr_counter=7'h0F, timeout=0, single access.
REQ-040 Poll clears: rs_sel=0, poll=1, LCD_DATA_IN=8'h80 for the first 3 captures then 8'h05 → 4 EN pulses, one done at k+1+4×50, busy_flag=0, addr_counter=5, timeout=0.
REQ-041 Poll timeout: MAX_POLLS=4, LCD_DATA_IN=8'hFF → exactly 4 EN pulses, done with timeout=1, busy_flag=1.
REQ-042 Reset in EN_HIGH: reset low mid-pulse → LCD_EN, LCD_RW and bus_own fall asynchronously, no done pulse, ready=1 after release.
REQ-043 Back-to-back with req held high: second SETUP starts the edge after done; req pulses mid-access are ignored; poll=1 with rs_sel=1 gives a single access.

Source files
------------

// File: rtl/lcd_reader_if.sv
// Host-side request/response and LCD bus pins of the LCD read engine.
interface lcd_reader_if;
  logic       req;
  logic       rs_sel;
  logic       poll;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       busy_flag;
  logic [6:0] addr_counter;
  logic       timeout;
  logic       bus_own;
  logic [7:0] LCD_DATA_IN;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;

  // Reader side: takes requests and drives the LCD control pins.
  modport slave (
    input  req, rs_sel, poll, LCD_DATA_IN,
    output ready, done, rdata, busy_flag, addr_counter, timeout, bus_own,
           LCD_EN, LCD_RS, LCD_RW
  );

  // Requester / environment side.
  modport master (
    output req, rs_sel, poll, LCD_DATA_IN,
    input  ready, done, rdata, busy_flag, addr_counter, timeout, bus_own,
           LCD_EN, LCD_RS, LCD_RW
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780-style LCD read engine: one timed read access (setup, EN pulse,
// hold, recovery), optionally repeated as a busy-flag poll until BF clears
// or the poll budget runs out.
module lcd_reader #(
  parameter int T_AS      = 8,
  parameter int T_PW      = 25,
  parameter int T_H       = 2,
  parameter int T_REC     = 15,
  parameter int MAX_POLLS = 255
) (
  input  logic      clock,
  input  logic      reset,
  lcd_reader_if.slave bus
);
  // A zero parameter still costs one cycle.
  localparam int AS_E  = (T_AS  < 1) ? 1 : T_AS;
  localparam int PW_E  = (T_PW  < 1) ? 1 : T_PW;
  localparam int H_E   = (T_H   < 1) ? 1 : T_H;
  localparam int REC_E = (T_REC < 1) ? 1 : T_REC;
  localparam int MP_E  = (MAX_POLLS < 1) ? 1 : MAX_POLLS;

  localparam int MAX_A = (AS_E > PW_E) ? AS_E : PW_E;
  localparam int MAX_B = (H_E > REC_E) ? H_E : REC_E;
  localparam int MAXT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXT < 2) ? 1 : $clog2(MAXT);
  localparam int PCW   = (MP_E < 2) ? 1 : $clog2(MP_E);

  // Counter reload values: a state lasts (load + 1) cycles.
  localparam logic [CW-1:0]  AS_LD   = CW'(AS_E - 1);
  localparam logic [CW-1:0]  PW_LD   = CW'(PW_E - 1);
  localparam logic [CW-1:0]  H_LD    = CW'(H_E - 1);
  localparam logic [CW-1:0]  REC_LD  = CW'(REC_E - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(MP_E - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, RECOVER} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PCW-1:0] poll_cnt;
  logic           poll_mode;
  logic           ready_q, done_q, timeout_q, bus_own_q;
  logic           lcd_en_q, lcd_rs_q, lcd_rw_q;
  logic [7:0]     rdata_q;
  logic           bf_q;
  logic [6:0]     ac_q;

  assign bus.ready        = ready_q;
  assign bus.done         = done_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy_flag    = bf_q;
  assign bus.addr_counter = ac_q;
  assign bus.timeout      = timeout_q;
  assign bus.bus_own      = bus_own_q;
  assign bus.LCD_EN       = lcd_en_q;
  assign bus.LCD_RS       = lcd_rs_q;
  assign bus.LCD_RW       = lcd_rw_q;

  // Access sequencer with all outputs registered on the state transitions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      poll_mode <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      bus_own_q <= 1'b0;
      lcd_en_q  <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_rw_q  <= 1'b0;
      rdata_q   <= '0;
      bf_q      <= 1'b0;
      ac_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            lcd_rs_q  <= bus.rs_sel;
            poll_mode <= bus.poll & ~bus.rs_sel;
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
            lcd_rw_q  <= 1'b1;
            bus_own_q <= 1'b1;
            cnt       <= AS_LD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_en_q <= 1'b1;
            cnt      <= PW_LD;
            state    <= EN_HIGH;
          end else cnt <= cnt - 1'b1;
        end
        EN_HIGH: begin
          if (cnt == '0) begin
            // Sample the bus on the last EN-high cycle, while data is valid.
            lcd_en_q <= 1'b0;
            rdata_q  <= bus.LCD_DATA_IN;
            if (!lcd_rs_q) begin
              bf_q <= bus.LCD_DATA_IN[7];
              ac_q <= bus.LCD_DATA_IN[6:0];
            end
            cnt   <= H_LD;
            state <= HOLD;
          end else cnt <= cnt - 1'b1;
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= REC_LD;
            state <= RECOVER;
          end else cnt <= cnt - 1'b1;
        end
        RECOVER: begin
          if (cnt == '0) begin
            if (poll_mode && rdata_q[7] && (poll_cnt < PC_LAST)) begin
              poll_cnt <= poll_cnt + 1'b1;
              cnt      <= AS_LD;
              state    <= SETUP;
            end else begin
              done_q    <= 1'b1;
              timeout_q <= poll_mode & rdata_q[7];
              ready_q   <= 1'b1;
              lcd_rw_q  <= 1'b0;
              bus_own_q <= 1'b0;
              state     <= IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
        default: begin
          lcd_en_q  <= 1'b0;
          lcd_rw_q  <= 1'b0;
          bus_own_q <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
